// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, coordinate width,
// colour constants and the position-to-sync/visible decode used by the timing block.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;
  localparam int CLK_DIV_DEF     = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [11:0]        rgb_t;

  localparam rgb_t BLACK = 12'h000;
  localparam rgb_t WHITE = 12'hfff;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic bright;
  } decode_t;

  // Sync pulses are active low at the start of each line/frame; all compares unsigned.
  function automatic decode_t decode_pos(
    input coord_t h,
    input coord_t v,
    input coord_t h_sync_len,
    input coord_t h_act_start,
    input coord_t h_act_end,
    input coord_t v_sync_len,
    input coord_t v_act_start,
    input coord_t v_act_end
  );
    decode_t d;
    d.h_sync = !(h < h_sync_len);
    d.v_sync = !(v < v_sync_len);
    d.bright = (h >= h_act_start) && (h < h_act_end) &&
               (v >= v_act_start) && (v < v_act_end);
    return d;
  endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Pixel-rate strobe: divides clk by CLK_DIV and emits a registered one-cycle pulse
// in the cycle after the divider reaches its last count.
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_reg;
  logic [DIV_W-1:0] div_cnt_next;
  logic             div_last;
  logic             pix_tick_reg;

  assign div_last     = (div_cnt_reg == DIV_LAST);
  assign div_cnt_next = div_last ? '0 : div_cnt_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_reg  <= '0;
      pix_tick_reg <= 1'b0;
    end else begin
      div_cnt_reg  <= div_cnt_next;
      pix_tick_reg <= div_last;
    end
  end

  assign pix_tick = pix_tick_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters advanced by pix_tick, with sync, visible
// window and frame-start flags registered alongside so all outputs stay aligned.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_tick,
  output logic [COORD_W-1:0] hCount,
  output logic [COORD_W-1:0] vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               bright,
  output logic               frame_start
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  coord_t  h_count_reg, h_count_next;
  coord_t  v_count_reg, v_count_next;
  logic    h_wrap, v_wrap;
  decode_t dec_next;
  logic    h_sync_reg, v_sync_reg, bright_reg, frame_start_reg;

  pix_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .pix_tick (pix_tick)
  );

  assign h_wrap = (h_count_reg == H_LAST);
  assign v_wrap = (v_count_reg == V_LAST);

  always_comb begin
    h_count_next = h_count_reg;
    v_count_next = v_count_reg;
    if (pix_tick) begin
      if (h_wrap) begin
        h_count_next = '0;
        v_count_next = v_wrap ? '0 : v_count_reg + 1'b1;
      end else begin
        h_count_next = h_count_reg + 1'b1;
      end
    end
  end

  // Decode the position that will be presented next cycle so flags never lag the counters.
  always_comb begin
    dec_next = decode_pos(h_count_next, v_count_next,
                          coord_t'(H_SYNC), coord_t'(H_ACT_START), coord_t'(H_ACT_END),
                          coord_t'(V_SYNC), coord_t'(V_ACT_START), coord_t'(V_ACT_END));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count_reg     <= '0;
      v_count_reg     <= '0;
      h_sync_reg      <= 1'b0;
      v_sync_reg      <= 1'b0;
      bright_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      h_count_reg     <= h_count_next;
      v_count_reg     <= v_count_next;
      h_sync_reg      <= dec_next.h_sync;
      v_sync_reg      <= dec_next.v_sync;
      bright_reg      <= dec_next.bright;
      frame_start_reg <= pix_tick && h_wrap && v_wrap;
    end
  end

  assign hCount      = h_count_reg;
  assign vCount      = v_count_reg;
  assign hSync       = h_sync_reg;
  assign vSync       = v_sync_reg;
  assign bright      = bright_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default, scaled and CLK_DIV=1 instances
// checked every cycle against an arithmetic raster model plus literal spot checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Instance A: default 640x480 timing
  logic       a_tick, a_hs, a_vs, a_br, a_fs;
  logic [9:0] a_h, a_v;
  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n), .pix_tick(a_tick), .hCount(a_h), .vCount(a_v),
    .hSync(a_hs), .vSync(a_vs), .bright(a_br), .frame_start(a_fs)
  );

  // Instance B: scaled raster, 20x10 pixels, CLK_DIV=2 (frame = 400 clk)
  logic       b_tick, b_hs, b_vs, b_br, b_fs;
  logic [9:0] b_h, b_v;
  vga_timing_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
    .V_TOTAL(10), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(8)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pix_tick(b_tick), .hCount(b_h), .vCount(b_v),
    .hSync(b_hs), .vSync(b_vs), .bright(b_br), .frame_start(b_fs)
  );

  // Instance C: CLK_DIV=1, 10x4 raster (frame = 40 clk)
  logic       c_tick, c_hs, c_vs, c_br, c_fs;
  logic [9:0] c_h, c_v;
  vga_timing_gen #(
    .CLK_DIV(1), .H_TOTAL(10), .H_SYNC(2), .H_ACT_START(3), .H_ACT_END(9),
    .V_TOTAL(4), .V_SYNC(1), .V_ACT_START(1), .V_ACT_END(3)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .pix_tick(c_tick), .hCount(c_h), .vCount(c_v),
    .hSync(c_hs), .vSync(c_vs), .bright(c_br), .frame_start(c_fs)
  );

  typedef struct packed {
    int tick; int h; int v; int hs; int vs; int br; int fs;
  } exp_t;

  // Model: e = clk edges since reset release; pixels advanced = ticks seen before edge e.
  function automatic exp_t calc(int e, int d, int ht, int hsl, int ha0, int ha1,
                                int vt, int vsl, int va0, int va1);
    exp_t r;
    int n, p;
    n = (e >= 1) ? (e - 1) / d : 0;
    p = n % (ht * vt);
    r.tick = ((e >= d) && (e % d == 0)) ? 1 : 0;
    r.h    = p % ht;
    r.v    = p / ht;
    r.hs   = (r.h >= hsl) ? 1 : 0;
    r.vs   = (r.v >= vsl) ? 1 : 0;
    r.br   = (r.h >= ha0 && r.h < ha1 && r.v >= va0 && r.v < va1) ? 1 : 0;
    r.fs   = (p == 0 && n > 0 && ((e - 1) % d == 0)) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input exp_t x, input logic tick,
                          input logic [9:0] h, input logic [9:0] v, input logic hs,
                          input logic vs, input logic br, input logic fs);
    chk({tag, ".pix_tick"},    int'(tick), x.tick);
    chk({tag, ".hCount"},      int'(h),    x.h);
    chk({tag, ".vCount"},      int'(v),    x.v);
    chk({tag, ".hSync"},       int'(hs),   x.hs);
    chk({tag, ".vSync"},       int'(vs),   x.vs);
    chk({tag, ".bright"},      int'(br),   x.br);
    chk({tag, ".frame_start"}, int'(fs),   x.fs);
  endtask

  int   e_cnt = 0;
  int   cyc = 0;
  logic valid = 1'b0;

  always @(posedge clk) begin
    e_cnt <= rst_n ? e_cnt + 1 : 0;
    valid <= valid | !rst_n;
    cyc   <= cyc + 1;
  end

  int last_fs_b = -1;
  int last_fs_c = -1;

  always @(negedge clk) begin
    if (valid) begin
      cmp_inst("A", calc(e_cnt, 4, 800, 96, 144, 784, 525, 2, 35, 515),
               a_tick, a_h, a_v, a_hs, a_vs, a_br, a_fs);
      cmp_inst("B", calc(e_cnt, 2, 20, 3, 5, 17, 10, 2, 3, 8),
               b_tick, b_h, b_v, b_hs, b_vs, b_br, b_fs);
      cmp_inst("C", calc(e_cnt, 1, 10, 2, 3, 9, 4, 1, 1, 3),
               c_tick, c_h, c_v, c_hs, c_vs, c_br, c_fs);
      if (e_cnt == 0) begin
        last_fs_b = -1;
        last_fs_c = -1;
      end
      if (b_fs === 1'b1) begin
        if (last_fs_b >= 0) chk("B.frame_period", cyc - last_fs_b, 400);
        last_fs_b = cyc;
      end
      if (c_fs === 1'b1) begin
        if (last_fs_c >= 0) chk("C.frame_period", cyc - last_fs_c, 40);
        last_fs_c = cyc;
      end
    end
  end

  int c = 0;

  task automatic wait_to(input int target);
    while (c < target) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic spot(input string name, input int act, input int exp);
    chk(name, act, exp);
    $display("check %-22s c=%0d got %0d want %0d", name, c, act, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    spot("rst.A.hCount", int'(a_h), 0);
    spot("rst.A.pix_tick", int'(a_tick), 0);
    spot("rst.A.hSync", int'(a_hs), 0);
    spot("rst.A.vSync", int'(a_vs), 0);
    spot("rst.B.frame_start", int'(b_fs), 0);
    rst_n = 1'b1;
    c = 0;

    wait_to(3);    spot("A.tick_c3", int'(a_tick), 0);
    wait_to(4);    spot("A.tick_c4", int'(a_tick), 1);
    wait_to(5);    spot("A.tick_c5", int'(a_tick), 0);
                   spot("A.hCount_c5", int'(a_h), 1);
                   spot("A.hSync_c5", int'(a_hs), 0);
                   spot("A.bright_c5", int'(a_br), 0);
    wait_to(8);    spot("A.tick_c8", int'(a_tick), 1);
    wait_to(41);   spot("C.fs_c41", int'(c_fs), 1);
    wait_to(42);   spot("C.fs_c42", int'(c_fs), 0);
    wait_to(79);   spot("B.vSync_line1", int'(b_vs), 0);
    wait_to(81);   spot("B.vSync_line2", int'(b_vs), 1);
                   spot("B.vCount_c81", int'(b_v), 2);
    wait_to(129);  spot("B.bright_4_3", int'(b_br), 0);
                   spot("B.hCount_c129", int'(b_h), 4);
    wait_to(131);  spot("B.bright_5_3", int'(b_br), 1);
    wait_to(313);  spot("B.bright_16_7", int'(b_br), 1);
    wait_to(315);  spot("B.bright_17_7", int'(b_br), 0);
    wait_to(331);  spot("B.bright_5_8", int'(b_br), 0);
    wait_to(381);  spot("A.hSync_h95", int'(a_hs), 0);
    wait_to(385);  spot("A.hSync_h96", int'(a_hs), 1);
    wait_to(399);  spot("B.hCount_c399", int'(b_h), 19);
                   spot("B.vCount_c399", int'(b_v), 9);
    wait_to(401);  spot("B.fs_wrap", int'(b_fs), 1);
                   spot("B.hCount_wrap", int'(b_h), 0);
    wait_to(402);  spot("B.fs_after", int'(b_fs), 0);
    wait_to(3197); spot("A.hCount_799", int'(a_h), 799);
                   spot("A.vCount_line0", int'(a_v), 0);
    wait_to(3201); spot("A.hCount_wrap", int'(a_h), 0);
                   spot("A.vCount_line1", int'(a_v), 1);
                   spot("A.hSync_line1", int'(a_hs), 0);

    // Reset pulse mid-line and mid-divider
    wait_to(3202);
    rst_n = 1'b0;
    wait_to(3203);
    spot("mrst.A.hCount", int'(a_h), 0);
    spot("mrst.A.vCount", int'(a_v), 0);
    spot("mrst.A.pix_tick", int'(a_tick), 0);
    spot("mrst.A.bright", int'(a_br), 0);
    spot("mrst.B.vCount", int'(b_v), 0);
    rst_n = 1'b1;
    c = 0;
    wait_to(3);    spot("mrst.A.tick_c3", int'(a_tick), 0);
    wait_to(4);    spot("mrst.A.tick_c4", int'(a_tick), 1);
    wait_to(5);    spot("mrst.A.hCount_c5", int'(a_h), 1);
    wait_to(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
